// File: rtl/seg_pkg.sv
// Shared constants and the BCD-to-segment table for the seven-segment scan driver.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK     = 8'hFF;
    localparam logic [3:0] DIGIT_BLANK   = 4'hF;
    localparam logic [2:0] POS_FRAME_END = 3'd6;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is leftmost. Codes A..F are blank.
    localparam logic [0:15][7:0] SEG_TABLE = {
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational 4-bit digit to active-low seven-segment pattern (dp always off).
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = bcd_to_seg(digit);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Frame-capturing, time-multiplexed driver for a common-anode seven-segment panel.
// Optional macro SEG_LEAD_ZERO_BLANK_EN blanks a leading zero on digit 0.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            pos,
    input  logic [3:0]            num,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] seg_pos,
    output logic                  frame_valid
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_LIT  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] display_bus;
    logic                       commit;

    assign commit = (pos == POS_FRAME_END);

    // Each digit owns a shadow/display pair; a frame-end marker copies all shadows at once.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : gen_digit
            logic [3:0] shadow_q, shadow_d;
            logic [3:0] display_q, display_d;

            always_comb begin
                shadow_d  = shadow_q;
                display_d = display_q;
                if (pos == 3'(gi)) begin
                    shadow_d = num;
                end
                if (commit) begin
                    display_d = shadow_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q  <= DIGIT_BLANK;
                    display_q <= DIGIT_BLANK;
                end else begin
                    shadow_q  <= shadow_d;
                    display_q <= display_d;
                end
            end

            assign display_bus[gi] = display_q;
        end
    endgenerate

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] seg_pos_q, seg_pos_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [3:0]            digit_sel;
    logic [7:0]            dec_seg;

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign digit_sel = display_bus[idx_q];

    seg_bcd_decode u_decode (
        .digit (digit_sel),
        .seg   (dec_seg)
    );

    // The first BLANK_CYCLES of each slot keep every anode off to hide ghosting.
    always_comb begin
        seg_d         = SEG_BLANK;
        seg_pos_d     = '1;
        frame_valid_d = frame_valid_q | commit;
        if (presc_q >= PRESC_LIT) begin
            seg_pos_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d     = dec_seg;
`ifdef SEG_LEAD_ZERO_BLANK_EN
            if ((idx_q == '0) && (digit_sel == 4'd0)) begin
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= '0;
            seg_q         <= SEG_BLANK;
            seg_pos_q     <= '1;
            frame_valid_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            seg_pos_q     <= seg_pos_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign seg         = seg_q;
    assign seg_pos     = seg_pos_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a short scan period (8 cycles/slot, 2 blank).
module tb_seg_scan_driver;

    localparam int NUM_DIGITS   = 6;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = NUM_DIGITS * SCAN_DIV;
    localparam int NUM_VECS     = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pos = 3'd7;
    logic [3:0] num = 4'hF;
    logic [7:0] seg;
    logic [5:0] seg_pos;
    logic       frame_valid;

    int t           = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [0:5][3:0] nums;
        logic            commit;
        logic [0:5][7:0] exp_seg;
        logic            exp_fv;
    } vec_t;

    typedef struct {
        logic [7:0] seg;
        logic [5:0] seg_pos;
    } exp_t;

    vec_t vecs [NUM_VECS];
    exp_t exp_q [$];

    seg_scan_driver #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pos         (pos),
        .num         (num),
        .seg         (seg),
        .seg_pos     (seg_pos),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; at a negedge the DUT prescaler equals t mod SCAN_DIV.
    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stop at the negedge whose registered outputs reflect slot k, prescaler p.
    task automatic wait_phase(input int k, input int p);
        int n = 0;
        while (!(t >= 1 && ((t - 1) % FRAME) == k * SCAN_DIV + p)) begin
            if (n == 3 * FRAME) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_phase: slot %0d p %0d not reached, t=%0d", k, p, t);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pos = 3'(i);
            num = v.nums[i];
            tick();
        end
        if (v.commit) begin
            pos = 3'd6;
            num = 4'h0;
            tick();
        end
        pos = 3'd7;
        num = 4'hF;
        tick();
    endtask

    initial begin
        vecs[0] = '{nums: {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, commit: 1'b0,
                    exp_seg: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp_fv: 1'b0};
        vecs[1] = '{nums: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, commit: 1'b1,
                    exp_seg: {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, exp_fv: 1'b1};
        vecs[2] = '{nums: {4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, commit: 1'b0,
                    exp_seg: {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, exp_fv: 1'b1};
        vecs[3] = '{nums: {4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, commit: 1'b1,
                    exp_seg: {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}, exp_fv: 1'b1};
        vecs[4] = '{nums: {4'd2, 4'd3, 4'd5, 4'd9, 4'hF, 4'hF}, commit: 1'b1,
                    exp_seg: {8'hA4, 8'hB0, 8'h92, 8'h90, 8'hFF, 8'hFF}, exp_fv: 1'b1};
        vecs[5] = '{nums: {4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'd8}, commit: 1'b1,
                    exp_seg: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80}, exp_fv: 1'b1};
`ifdef SEG_LEAD_ZERO_BLANK_EN
        vecs[6] = '{nums: {4'd0, 4'd7, 4'd0, 4'd5, 4'd0, 4'd9}, commit: 1'b1,
                    exp_seg: {8'hFF, 8'hF8, 8'hC0, 8'h92, 8'hC0, 8'h90}, exp_fv: 1'b1};
`else
        vecs[6] = '{nums: {4'd0, 4'd7, 4'd0, 4'd5, 4'd0, 4'd9}, commit: 1'b1,
                    exp_seg: {8'hC0, 8'hF8, 8'hC0, 8'h92, 8'hC0, 8'h90}, exp_fv: 1'b1};
`endif

        // Reset held for three edges with pos=7.
        repeat (3) tick();
        chk("reset_seg", 32'(seg), 32'h0FF);
        chk("reset_seg_pos", 32'(seg_pos), 32'h03F);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("release_seg_pos", 32'(seg_pos), 32'h03F);
        chk("release_frame_valid", 32'(frame_valid), 32'h0);

        for (int i = 0; i < NUM_VECS; i++) begin
            send_frame(vecs[i]);
            for (int k = 0; k < NUM_DIGITS; k++) begin
                exp_t e;
                e.seg     = vecs[i].exp_seg[k];
                e.seg_pos = ~(6'b1 << k);
                exp_q.push_back(e);
            end
            chk($sformatf("v%0d_frame_valid", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
            for (int k = 0; k < NUM_DIGITS; k++) begin
                exp_t e;
                wait_phase(k, BLANK_CYCLES - 1);
                chk($sformatf("v%0d_slot%0d_blank_seg", i, k), 32'(seg), 32'h0FF);
                chk($sformatf("v%0d_slot%0d_blank_pos", i, k), 32'(seg_pos), 32'h03F);
                wait_phase(k, BLANK_CYCLES);
                e = exp_q.pop_front();
                chk($sformatf("v%0d_slot%0d_seg", i, k), 32'(seg), 32'(e.seg));
                chk($sformatf("v%0d_slot%0d_seg_pos", i, k), 32'(seg_pos), 32'(e.seg_pos));
            end
            $display("vec %0d: digits %h commit=%0b frame_valid=%0b", i, vecs[i].nums,
                     vecs[i].commit, frame_valid);
        end

        // Reset asserted while the prescaler sits at 5 inside the digit-3 slot.
        wait_phase(3, 4);
        chk("pre_reset_seg", 32'(seg), 32'h092);
        chk("pre_reset_seg_pos", 32'(seg_pos), 32'h037);
        rst = 1'b1;
        tick();
        chk("midslot_reset_seg", 32'(seg), 32'h0FF);
        chk("midslot_reset_seg_pos", 32'(seg_pos), 32'h03F);
        chk("midslot_reset_frame_valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("restart_p0_seg_pos", 32'(seg_pos), 32'h03F);
        tick();
        chk("restart_p1_seg_pos", 32'(seg_pos), 32'h03F);
        tick();
        chk("restart_p2_seg_pos", 32'(seg_pos), 32'h03E);
        chk("restart_p2_seg", 32'(seg), 32'h0FF);
        chk("restart_frame_valid", 32'(frame_valid), 32'h0);
        $display("midslot reset: scan restarted at digit 0, seg_pos=%h", seg_pos);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
